// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one memory port between the instruction-fetch requester (IF) and the
// execute load/store requester (EX). Each granted access runs the fixed
// sequence IDLE -> GRANT -> ACCESS -> CAPTURE -> ACK -> IDLE. When both
// requesters contend in IDLE, the one that was not granted last wins.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : ACCESS aborts to ACK with err=1 after TIMEOUT_CYC cycles
//               without mfc.
//   undefined : ACCESS waits for mfc indefinitely and err stays 0.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   reset       synchronous, active-low reset
//   if_req      IF read request (level, held with if_addr until if_ack)
//   if_addr     IF read address
//   if_rdata    IF read data, valid while if_ack=1, then held
//   if_ack      one-cycle completion pulse to IF
//   ex_req      EX request (level, held with ex_we/ex_addr/ex_wdata until ex_ack)
//   ex_we       EX direction, 1=write 0=read
//   ex_addr     EX address
//   ex_wdata    EX write data
//   ex_rdata    EX read data, valid while ex_ack=1, then held
//   ex_ack      one-cycle completion pulse to EX
//   mem_addr    memory address, latched in GRANT and held between accesses
//   mem_wdata   memory write data, latched in GRANT for EX writes only
//   mem_rdata   memory read data, valid when mfc=1
//   mem_rw      memory direction, 1=read 0=write
//   mem_enable  memory cycle active (ACCESS state)
//   mfc         memory function complete, only looked at in ACCESS
//   busy        high whenever the sequencer is not IDLE
//   err         timeout flag, pulses together with the ack
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          ex_req,
    input  logic          ex_we,
    input  logic [AW-1:0] ex_addr,
    input  logic [DW-1:0] ex_wdata,
    output logic [DW-1:0] ex_rdata,
    output logic          ex_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_rw,
    output logic          mem_enable,
    input  logic          mfc,
    output logic          busy,
    output logic          err
);

`ifdef MEM_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_ACCESS,
        S_CAPTURE,
        S_ACK
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_EX = 1'b1
    } owner_t;

    state_t          state;
    state_t          next_state;
    owner_t          owner;
    owner_t          next_owner;
    owner_t          last_grant;
    logic [DW-1:0]   mdr;         // memory data sampled on the mfc edge
    logic [TO_W-1:0] to_cnt;      // ACCESS cycles seen with mfc=0
    logic            timed_out;
    logic            timeout_hit;

    // Constant-false in the default build, so the counter logic folds away.
    assign timeout_hit = TIMEOUT_EN && !mfc && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // State register.
    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and arbitration decision.
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        next_state = state;
        next_owner = OWN_IF;
        unique case (state)
            S_IDLE: begin
                if (if_req || ex_req) begin
                    next_state = S_GRANT;
                    if (if_req && ex_req) begin
                        // Round-robin: the requester not granted last time wins.
                        next_owner = (last_grant == OWN_IF) ? OWN_EX : OWN_IF;
                    end else if (ex_req) begin
                        next_owner = OWN_EX;
                    end
                end
            end
            S_GRANT:   next_state = S_ACCESS;
            S_ACCESS: begin
                if (mfc) begin
                    next_state = S_CAPTURE;
                end else if (timeout_hit) begin
                    next_state = S_ACK;
                end
            end
            S_CAPTURE: next_state = S_ACK;
            S_ACK:     next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Datapath: owner tracking, memory-side latches and read-data capture.
    // NOTE: the data registers are reset as well because every output must
    // read 0 out of reset, including the held read data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner      <= OWN_IF;
            last_grant <= OWN_EX;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_rw     <= 1'b0;
            mdr        <= '0;
            if_rdata   <= '0;
            ex_rdata   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (next_state == S_GRANT) begin
                        owner      <= next_owner;
                        last_grant <= next_owner;
                    end
                end
                S_GRANT: begin
                    if (owner == OWN_EX) begin
                        mem_addr <= ex_addr;
                        mem_rw   <= ~ex_we;
                        if (ex_we) begin
                            mem_wdata <= ex_wdata;
                        end
                    end else begin
                        mem_addr <= if_addr;
                        mem_rw   <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    // mem_rdata is only guaranteed while mfc is high, so grab it
                    // here and hand it to the requester in CAPTURE.
                    if (mfc) begin
                        mdr <= mem_rdata;
                    end
                end
                S_CAPTURE: begin
                    if (mem_rw) begin
                        if (owner == OWN_EX) begin
                            ex_rdata <= mdr;
                        end else begin
                            if_rdata <= mdr;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Timeout counter and flag; cleared at every grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            to_cnt    <= '0;
            timed_out <= 1'b0;
        end else if (state == S_GRANT) begin
            to_cnt    <= '0;
            timed_out <= 1'b0;
        end else if (TIMEOUT_EN && state == S_ACCESS && !mfc) begin
            to_cnt <= to_cnt + 1'b1;
            if (timeout_hit) begin
                timed_out <= 1'b1;
            end
        end
    end

    assign busy       = (state != S_IDLE);
    assign mem_enable = (state == S_ACCESS);
    assign if_ack     = (state == S_ACK) && (owner == OWN_IF);
    assign ex_ack     = (state == S_ACK) && (owner == OWN_EX);
    assign err        = (state == S_ACK) && timed_out;

endmodule
